// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, opcode constants and the UART-side FSM encoding.
package alu_pkg;

  localparam int unsigned SIZEDATA_DEF = 8;
  localparam int unsigned SIZEOP_DEF   = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;

  typedef enum logic [2:0] {
    GET_A    = 3'd0,
    GET_B    = 3'd1,
    GET_OP   = 3'd2,
    EXEC     = 3'd3,
    SEND_RES = 3'd4,
    WAIT_RES = 3'd5,
    SEND_CRY = 3'd6,
    WAIT_CRY = 3'd7
  } state_e;

endpackage

// File: rtl/alu_uart_if_if.sv
// Bus bundle between the UART/ALU glue and its surroundings (receiver, transmitter, ALU).
interface alu_uart_if_if
  import alu_pkg::*;
#(
  parameter int unsigned SIZEDATA = SIZEDATA_DEF,
  parameter int unsigned SIZEOP   = SIZEOP_DEF
);

  logic                RX_DONE;
  logic [SIZEDATA-1:0] RX_DATA;
  logic                TX_DONE;
  logic                TX_START;
  logic [SIZEDATA-1:0] TX_DATA;
  logic [SIZEDATA-1:0] DATOA;
  logic [SIZEDATA-1:0] DATOB;
  logic [SIZEOP-1:0]   OPCODE;
  logic [SIZEDATA-1:0] RESULT;
  logic                CARRY;
  logic                BUSY;

  modport slave (
    input  RX_DONE, RX_DATA, TX_DONE, RESULT, CARRY,
    output TX_START, TX_DATA, DATOA, DATOB, OPCODE, BUSY
  );

  modport master (
    output RX_DONE, RX_DATA, TX_DONE, RESULT, CARRY,
    input  TX_START, TX_DATA, DATOA, DATOB, OPCODE, BUSY
  );

endinterface

// File: rtl/alu_uart_if.sv
// Collects operand A, operand B and opcode from the UART receiver, then sends the ALU result
// (and, with ALU_UART_IF_CARRY_EN defined, a second byte holding the carry) to the transmitter.
module alu_uart_if
  import alu_pkg::*;
#(
  parameter int unsigned SIZEDATA = SIZEDATA_DEF,
  parameter int unsigned SIZEOP   = SIZEOP_DEF
) (
  input  logic          CLK,
  input  logic          RST_N,
  alu_uart_if_if.slave  bus
);

  state_e              state_q;
  logic [SIZEDATA-1:0] dato_a_q;
  logic [SIZEDATA-1:0] dato_b_q;
  logic [SIZEOP-1:0]   opcode_q;
  logic [SIZEDATA-1:0] tx_data_q;
  logic                tx_start_q;
  logic                busy_q;

  // Sequencer; BUSY and TX_START are updated on the same edge as the state they describe.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= GET_A;
      dato_a_q   <= '0;
      dato_b_q   <= '0;
      opcode_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        GET_A: if (bus.RX_DONE) begin
          dato_a_q <= bus.RX_DATA;
          busy_q   <= 1'b1;
          state_q  <= GET_B;
        end
        GET_B: if (bus.RX_DONE) begin
          dato_b_q <= bus.RX_DATA;
          state_q  <= GET_OP;
        end
        GET_OP: if (bus.RX_DONE) begin
          opcode_q <= bus.RX_DATA[SIZEOP-1:0];
          state_q  <= EXEC;
        end
        EXEC: begin
          tx_data_q  <= bus.RESULT;
          tx_start_q <= 1'b1;
          state_q    <= SEND_RES;
        end
        SEND_RES: state_q <= WAIT_RES;
        WAIT_RES: if (bus.TX_DONE) begin
`ifdef ALU_UART_IF_CARRY_EN
          tx_data_q  <= {{(SIZEDATA-1){1'b0}}, bus.CARRY};
          tx_start_q <= 1'b1;
          state_q    <= SEND_CRY;
`else
          busy_q  <= 1'b0;
          state_q <= GET_A;
`endif
        end
`ifdef ALU_UART_IF_CARRY_EN
        SEND_CRY: state_q <= WAIT_CRY;
        WAIT_CRY: if (bus.TX_DONE) begin
          busy_q  <= 1'b0;
          state_q <= GET_A;
        end
`endif
        default: begin
          busy_q  <= 1'b0;
          state_q <= GET_A;
        end
      endcase
    end
  end

  assign bus.DATOA    = dato_a_q;
  assign bus.DATOB    = dato_b_q;
  assign bus.OPCODE   = opcode_q;
  assign bus.TX_DATA  = tx_data_q;
  assign bus.TX_START = tx_start_q;
  assign bus.BUSY     = busy_q;

endmodule

// File: tb/tb_alu_uart_if.sv
// Directed bench for alu_uart_if with a behavioural ALU; expectations follow ALU_UART_IF_CARRY_EN.
module tb_alu_uart_if;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_uart_if_if #(.SIZEDATA(8), .SIZEOP(6)) bus ();

  alu_uart_if #(.SIZEDATA(8), .SIZEOP(6)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU
  logic [8:0] alu_w;
  always_comb begin
    alu_w = '0;
    case (bus.OPCODE)
      OP_ADD:  alu_w = {1'b0, bus.DATOA} + {1'b0, bus.DATOB};
      OP_SUB:  alu_w = {1'b0, bus.DATOA} - {1'b0, bus.DATOB};
      OP_AND:  alu_w = {1'b0, bus.DATOA & bus.DATOB};
      OP_OR:   alu_w = {1'b0, bus.DATOA | bus.DATOB};
      OP_XOR:  alu_w = {1'b0, bus.DATOA ^ bus.DATOB};
      OP_NOR:  alu_w = {1'b0, ~(bus.DATOA | bus.DATOB)};
      OP_SRL:  alu_w = {1'b0, bus.DATOA >> bus.DATOB};
      OP_SRA:  alu_w = {1'b0, 8'($signed(bus.DATOA) >>> bus.DATOB)};
      default: alu_w = '0;
    endcase
    bus.RESULT = alu_w[7:0];
    bus.CARRY  = alu_w[8];
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.RX_DATA = b;
    bus.RX_DONE = 1'b1;
    @(posedge clk); #1;
    bus.RX_DONE = 1'b0;
  endtask

  task automatic pulse_tx_done(input int delay);
    repeat (delay) @(posedge clk);
    #1 bus.TX_DONE = 1'b1;
    @(posedge clk); #1;
    bus.TX_DONE = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({bus.BUSY, bus.TX_START, bus.TX_DATA, bus.DATOA, bus.DATOB, bus.OPCODE} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b start=%b tx=%h a=%h b=%h op=%h exp all 0",
               bus.BUSY, bus.TX_START, bus.TX_DATA, bus.DATOA, bus.DATOB, bus.OPCODE);
    end
  endtask

  task automatic test_add;
    send_byte(8'h05); send_byte(8'h03);
    checks++;
    if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL add_busy got %b exp 1", bus.BUSY); end
    send_byte(8'h20);
    checks++;
    if ({bus.DATOA, bus.DATOB, bus.OPCODE} !== {8'h05, 8'h03, 6'h20}) begin
      errors++; $display("FAIL add_operands got %h %h %h exp 05 03 20", bus.DATOA, bus.DATOB, bus.OPCODE);
    end
    checks++;
    if (bus.TX_START !== 1'b0) begin errors++; $display("FAIL add_start_early got %b exp 0", bus.TX_START); end
    @(posedge clk); #1;
    checks++;
    if (bus.TX_START !== 1'b1 || bus.TX_DATA !== 8'h08) begin
      errors++; $display("FAIL add_result got start=%b tx=%h exp 1 08", bus.TX_START, bus.TX_DATA);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.TX_START !== 1'b0) begin errors++; $display("FAIL add_start_width got %b exp 0", bus.TX_START); end
    pulse_tx_done(3);
`ifdef ALU_UART_IF_CARRY_EN
    checks++;
    if (bus.TX_START !== 1'b1 || bus.TX_DATA !== 8'h00) begin
      errors++; $display("FAIL add_carry got start=%b tx=%h exp 1 00", bus.TX_START, bus.TX_DATA);
    end
    pulse_tx_done(2);
`endif
    checks++;
    if (bus.BUSY !== 1'b0 || {bus.DATOA, bus.DATOB, bus.OPCODE} !== {8'h05, 8'h03, 6'h20}) begin
      errors++; $display("FAIL add_hold got busy=%b %h %h %h exp 0 05 03 20",
                         bus.BUSY, bus.DATOA, bus.DATOB, bus.OPCODE);
    end
  endtask

  task automatic test_add_carry;
    send_byte(8'hFF); send_byte(8'h01); send_byte(8'h20);
    @(posedge clk); #1;
    checks++;
    if (bus.TX_START !== 1'b1 || bus.TX_DATA !== 8'h00) begin
      errors++; $display("FAIL carry_result got start=%b tx=%h exp 1 00", bus.TX_START, bus.TX_DATA);
    end
    pulse_tx_done(4);
`ifdef ALU_UART_IF_CARRY_EN
    checks++;
    if (bus.TX_START !== 1'b1 || bus.TX_DATA !== 8'h01 || bus.BUSY !== 1'b1) begin
      errors++; $display("FAIL carry_byte got start=%b tx=%h busy=%b exp 1 01 1",
                         bus.TX_START, bus.TX_DATA, bus.BUSY);
    end
    pulse_tx_done(4);
`endif
    checks++;
    if (bus.BUSY !== 1'b0 || bus.TX_START !== 1'b0) begin
      errors++; $display("FAIL carry_done got busy=%b start=%b exp 0 0", bus.BUSY, bus.TX_START);
    end
  endtask

  task automatic test_slow_tx;
    logic bad;
    bad = 1'b0;
    send_byte(8'h03); send_byte(8'h05); send_byte(8'h22);
    @(posedge clk); #1;
    checks++;
    if (bus.TX_START !== 1'b1 || bus.TX_DATA !== 8'hFE) begin
      errors++; $display("FAIL sub_result got start=%b tx=%h exp 1 fe", bus.TX_START, bus.TX_DATA);
    end
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (bus.TX_DATA !== 8'hFE || bus.TX_START !== 1'b0 || bus.BUSY !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL sub_hold got unstable=%b exp 0", bad); end
    pulse_tx_done(0);
`ifdef ALU_UART_IF_CARRY_EN
    checks++;
    if (bus.TX_START !== 1'b1 || bus.TX_DATA !== 8'h01) begin
      errors++; $display("FAIL sub_carry got start=%b tx=%h exp 1 01", bus.TX_START, bus.TX_DATA);
    end
    pulse_tx_done(1);
`endif
  endtask

  task automatic test_drop;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h20);
    repeat (3) @(posedge clk);
    send_byte(8'hAA);
    checks++;
    if (bus.DATOA !== 8'h01 || bus.BUSY !== 1'b1 || bus.TX_DATA !== 8'h03 || bus.TX_START !== 1'b0) begin
      errors++; $display("FAIL drop_rx got a=%h busy=%b tx=%h start=%b exp 01 1 03 0",
                         bus.DATOA, bus.BUSY, bus.TX_DATA, bus.TX_START);
    end
    pulse_tx_done(1);
`ifdef ALU_UART_IF_CARRY_EN
    pulse_tx_done(1);
`endif
    pulse_tx_done(1);
    checks++;
    if (bus.BUSY !== 1'b0 || bus.TX_START !== 1'b0) begin
      errors++; $display("FAIL idle_txdone got busy=%b start=%b exp 0 0", bus.BUSY, bus.TX_START);
    end
    send_byte(8'h0F); send_byte(8'hF0); send_byte(8'h25);
    @(posedge clk); #1;
    checks++;
    if (bus.DATOA !== 8'h0F || bus.TX_START !== 1'b1 || bus.TX_DATA !== 8'hFF) begin
      errors++; $display("FAIL or_result got a=%h start=%b tx=%h exp 0f 1 ff",
                         bus.DATOA, bus.TX_START, bus.TX_DATA);
    end
    pulse_tx_done(1);
`ifdef ALU_UART_IF_CARRY_EN
    pulse_tx_done(1);
`endif
  endtask

  task automatic test_reset_mid;
    send_byte(8'h12); send_byte(8'h34);
    checks++;
    if (bus.DATOA !== 8'h12 || bus.DATOB !== 8'h34 || bus.BUSY !== 1'b1) begin
      errors++; $display("FAIL mid_load got a=%h b=%h busy=%b exp 12 34 1", bus.DATOA, bus.DATOB, bus.BUSY);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.BUSY, bus.TX_START, bus.TX_DATA, bus.DATOA, bus.DATOB, bus.OPCODE} !== '0) begin
      errors++; $display("FAIL async_reset got busy=%b start=%b tx=%h a=%h b=%h op=%h exp all 0",
                         bus.BUSY, bus.TX_START, bus.TX_DATA, bus.DATOA, bus.DATOB, bus.OPCODE);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send_byte(8'h01); send_byte(8'h01); send_byte(8'h20);
    @(posedge clk); #1;
    checks++;
    if (bus.TX_START !== 1'b1 || bus.TX_DATA !== 8'h02 || bus.DATOA !== 8'h01) begin
      errors++; $display("FAIL post_reset got start=%b tx=%h a=%h exp 1 02 01",
                         bus.TX_START, bus.TX_DATA, bus.DATOA);
    end
    pulse_tx_done(1);
`ifdef ALU_UART_IF_CARRY_EN
    checks++;
    if (bus.TX_DATA !== 8'h00) begin errors++; $display("FAIL post_reset_carry got %h exp 00", bus.TX_DATA); end
    pulse_tx_done(1);
`endif
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.RX_DONE = 1'b0;
    bus.RX_DATA = '0;
    bus.TX_DONE = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    test_add;
    test_add_carry;
    test_slow_tx;
    test_drop;
    test_reset_mid;
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
